y_divider_seq: RTL and testbench

Sequential restoring divider for the y-series arithmetic datapath. It is the inverse-operation companion to the combinational yAdder/yArith blocks. It accepts a dividend/divisor pair on a start pulse, runs one shift-subtract iteration per clock, and returns quotient and remainder with a done pulse. It sits beside the ALU and serves DIV/REM-type operations that are too deep for a single combinational cycle.

---
 rtl/y_divider_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_y_divider_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/y_divider_seq.sv
// ----------------------------------------------------------------------------
// y_divider_seq
//   Sequential restoring divider for the y-series arithmetic datapath.
//   One shift-subtract iteration per clock; quotient and remainder are
//   returned together with a single-cycle done pulse.
//
//   Optional build macro: YDIV_SIGNED_EN
//     undefined : unsigned division only (IDLE -> RUN -> DONE)
//     defined   : two's-complement truncating division; an extra FIX cycle
//                 restores the result signs (IDLE -> RUN -> FIX -> DONE)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request pulse, accepted only while busy = 0
//   dividend     numerator, captured on an accepted start
//   divisor      denominator, captured on an accepted start
//   busy         high while an operation is in flight
//   done         one-cycle pulse when quotient/remainder become valid
//   quotient     result quotient, held until the next result
//   remainder    result remainder, held until the next result
//   div_by_zero  last completed operation had a zero divisor
// ----------------------------------------------------------------------------
module y_divider_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

`ifdef YDIV_SIGNED_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FIX = 2'd2, ST_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd3} state_t;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_divisor;
  logic [CNT_W-1:0] r_cnt;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic             w_accept;
  logic             w_run_zero;
  logic             w_run_last;
  logic             w_finish;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  // A zero-divisor operation spends one cycle in RUN without iterating.
  assign w_run_zero = (r_state == ST_RUN) && r_zero;
  assign w_run_last = (r_state == ST_RUN) && !r_zero && (r_cnt == CNT_W'(1));

  // Restoring step: remainder stays below the divisor, so the top bit of the
  // (WIDTH+1)-bit trial difference is a valid sign.
  assign w_shift   = {r_rem, r_q[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_divisor};
  assign w_ge      = ~w_trial[WIDTH];
  assign w_rem_nxt = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_q_nxt   = {r_q[WIDTH-2:0], w_ge};

`ifdef YDIV_SIGNED_EN
  logic r_sign_q;
  logic r_sign_r;
  assign w_a_mag  = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
  assign w_b_mag  = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
  assign w_finish = w_run_zero || (r_state == ST_FIX);
`else
  assign w_a_mag  = dividend;
  assign w_b_mag  = divisor;
  assign w_finish = w_run_zero || w_run_last;
`endif

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
        else       w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_run_zero) begin
          w_state_nxt = ST_DONE;
        end else if (w_run_last) begin
`ifdef YDIV_SIGNED_EN
          w_state_nxt = ST_FIX;
`else
          w_state_nxt = ST_DONE;
`endif
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
`ifdef YDIV_SIGNED_EN
      ST_FIX:  w_state_nxt = ST_DONE;
`endif
      ST_DONE: begin
        if (start) w_state_nxt = ST_RUN;
        else       w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem     <= '0;
      r_q       <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_zero    <= 1'b0;
    end else if (w_accept) begin
      r_rem     <= '0;
      // The raw dividend is kept for a zero divisor: it becomes the remainder.
      r_q       <= (divisor == '0) ? dividend : w_a_mag;
      r_divisor <= w_b_mag;
      r_cnt     <= CNT_W'(WIDTH);
      r_zero    <= (divisor == '0);
    end else if ((r_state == ST_RUN) && !r_zero) begin
      r_rem <= w_rem_nxt;
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt - CNT_W'(1);
    end else begin
      r_rem <= r_rem;
      r_q   <= r_q;
    end
  end

`ifdef YDIV_SIGNED_EN
  // Operand signs for the FIX cycle (truncating division).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
    end else if (w_accept) begin
      r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_sign_r <= dividend[WIDTH-1];
    end else begin
      r_sign_q <= r_sign_q;
      r_sign_r <= r_sign_r;
    end
  end
`endif

  // Result registers, done pulse and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= w_finish;
`ifdef YDIV_SIGNED_EN
      r_busy <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_FIX);
`else
      r_busy <= (w_state_nxt == ST_RUN);
`endif
      if (w_run_zero) begin
        r_quotient  <= '1;
        r_remainder <= r_q;
        r_dbz       <= 1'b1;
      end else if (w_finish) begin
`ifdef YDIV_SIGNED_EN
        r_quotient  <= r_sign_q ? (~r_q + WIDTH'(1)) : r_q;
        r_remainder <= r_sign_r ? (~r_rem + WIDTH'(1)) : r_rem;
`else
        r_quotient  <= w_q_nxt;
        r_remainder <= w_rem_nxt;
`endif
        r_dbz       <= 1'b0;
      end else if (w_accept) begin
        r_dbz <= 1'b0;
      end else begin
        r_dbz <= r_dbz;
      end
    end
  end

endmodule

// File: tb/tb_y_divider_seq.sv
module tb_y_divider_seq;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb_q[$];

  y_divider_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour built from the language's own / and % operators.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int e0);
    exp_t e;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa    = a;
    sb    = b;
    e.dbz = 1'b0;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
      e.cyc = e0 + 1;
    end else begin
`ifdef YDIV_SIGNED_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = a;
        e.r = '0;
      end else begin
        e.q = sa / sb;
        e.r = sa % sb;
      end
      e.cyc = e0 + W + 1;
`else
      e.q   = a / b;
      e.r   = a % b;
      e.cyc = e0 + W;
`endif
    end
    return e;
  endfunction

  // Issue one accepted operation and queue its expected result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb_q.push_back(model(a, b, cyc));
    check_eq("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      check_eq("timeout", 64'd0, 64'd1);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  // Scoreboard consumer: compare every done pulse with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("quotient",    {32'd0, quotient},    {32'd0, e.q});
        check_eq("remainder",   {32'd0, remainder},   {32'd0, e.r});
        check_eq("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
        check_eq("latency",     64'(cyc),             64'(e.cyc));
        check_eq("busy_w_done", {63'd0, busy},        64'd0);
      end
    end
  end

  initial begin
    int k;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_q",    {32'd0, quotient}, 64'd0);
    check_eq("rst_r",    {32'd0, remainder}, 64'd0);
    check_eq("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
    rst_n = 1'b1;

    // Basic and divide-by-zero.
    run_op(32'd100, 32'd7);
    wait_idle();
    run_op(32'h1234_5678, 32'd0);
    wait_idle();

    // Back-to-back: second start lands in the done cycle.
    run_op(32'hFFFF_FFFF, 32'd1);
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("b2b_done_seen", {63'd0, done}, 64'd1);
    start    = 1'b1;
    dividend = 32'hFFFF_FFFF;
    divisor  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb_q.push_back(model(32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc));
    wait_idle();

    // Start while busy is ignored.
    run_op(32'd1000, 32'd10);
    repeat (8) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd5;
    divisor  = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset mid-operation aborts with no done pulse.
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_done", {63'd0, done}, 64'd0);
    check_eq("abort_q",    {32'd0, quotient}, 64'd0);
    check_eq("abort_r",    {32'd0, remainder}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd9, 32'd3);
    wait_idle();

`ifdef YDIV_SIGNED_EN
    run_op(-32'sd7, 32'sd2);
    wait_idle();
    run_op(32'sd7, -32'sd2);
    wait_idle();
    run_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    run_op(32'h8000_0000, 32'd0);
    wait_idle();
`endif

    // Random pairs, divisor width varied to get non-trivial quotients.
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      run_op(a, b);
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
